universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
- Parametrised universal shift register with parallel load.
- Supports shift left/right, rotate left/right and arithmetic shift right, with serial inputs at both ends.
- Supports free-running shifting plus a counted-burst mode with a Busy/Done handshake.
- Serves as the general serialiser/deserialiser and bit-manipulation register used by the serial-link and datapath blocks.

Parameters:
- BITS, 8, register width; must be >= 2.
- CW, $clog2(BITS+1), width of the burst count input and of the internal remaining counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Load  input  1  parallel load strobe.
- data  input  BITS  parallel load value.
- Mode  input  3  operation select (see Behaviour).
- En  input  1  free-run enable; one operation per cycle while idle.
- Start  input  1  begin a counted burst of Count operations.
- Count  input  CW  burst length (number of operations).
- SerInL  input  1  serial bit entering at the MSB end (right shifts).
- SerInR  input  1  serial bit entering at the LSB end (left shifts).
- Q  output  BITS  register contents.
- SerOutL  output  1  Q[BITS-1], combinational from register.
- SerOutR  output  1  Q[0], combinational from register.
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: one clock, synchronous, active-high. When RST=1 at a CLK edge: Q=0, Busy=0, Done=0, latched mode=000, remaining counter=0.
- Mode encoding:
  - 000: hold.
  - 001: shift left, Q<={Q[BITS-2:0],SerInR}.
  - 010: shift right, Q<={SerInL,Q[BITS-1:1]}.
  - 011: rotate left.
  - 100: rotate right.
  - 101: arithmetic shift right, MSB replicated.
  - 110/111: hold.
- Priority per edge: RST > Load > active burst > Start > En > hold.
- Load:
  - Q<=data.
  - Aborts any burst: Busy<=0, Done<=0, no Done pulse.
- Start, accepted only when Busy=0 and Load=0:
  - Latch Mode into the burst mode register.
  - Load the remaining counter with Count.
  - No shift occurs on the Start edge.
  - If Count!=0: Busy<=1, Done<=0.
  - If Count==0: Busy stays 0, Done<=1 for one cycle, Q unchanged.
- Burst (Busy=1):
  - Each edge applies one operation of the latched mode; Mode changes during the burst are ignored.
  - Each edge decrements the remaining counter.
  - On the edge where remaining==1, the final operation is applied, Busy<=0 and Done<=1.
  - Busy is high for exactly Count cycles.
  - Start and En are ignored while Busy=1.
- Done is 0 on every edge except the one cycle after burst completion (or after a Count==0 Start).
- Free run: Busy=0, no Load, no Start, En=1 -> one operation per edge using the live Mode.
- Serial inputs are sampled on the same edge as the operation that uses them. Rotates and arithmetic shift ignore SerInL/SerInR.
- Count values greater than BITS are legal: the burst performs exactly Count operations. Rotate by BITS returns the original value.
- Start and En asserted together while idle: Start wins and En is ignored that cycle.
- Reset mid-burst: Busy/Done/counter clear immediately on that edge, with no Done pulse.

Optional Feature:
- Macro USR_PARITY_EN.
- Defined:
  - Adds output port Parity (1 bit) = registered XOR-reduction of the next Q value, so Parity always matches the current Q.
  - Parity resets to 0 and is updated on every edge that writes Q.
- Undefined:
  - No Parity port and no parity logic.
  - All other behaviour is identical.

Test Plan (BITS=8):
1. RST=1 for 2 edges, then Load with data=8'h0A -> Q=8'h00 during reset; Q=8'h0A one edge after Load; SerOutR=0, SerOutL=0.
2. Q=8'h0A, En=1, Mode=001, SerInR=1 for 6 edges -> Q sequence 15,2B,57,AF,5F,BF (hex). Then Mode=010, SerInL=0 for 4 edges -> Q=8'h0B.
3. Q=8'h81, Start with Count=3, Mode=011 -> Busy high for exactly 3 cycles, Q=8'h0C, Done single-cycle pulse as Busy falls. Toggling Mode/Start/En during the burst has no effect.
4. Q=8'h80, Start with Count=2, Mode=101 -> Q=8'hE0. Then Start with Count=0 -> Done pulses next cycle, Busy stays 0, Q stays 8'hE0.
5. Start with Count=8, Mode=100, Q=8'h5A; assert Load data=8'h33 after 3 burst cycles -> Q=8'h33, Busy=0, no Done pulse. A separate run with RST mid-burst -> Q=0, Busy=0, Done=0.
6. With USR_PARITY_EN defined: load 8'h07 -> Parity=1; shift left with SerInR=0 -> Q=8'h0E, Parity=1; load 8'h03 -> Parity=0.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, shifts/rotates/arith shift, free-run and counted bursts.
// Optional USR_PARITY_EN macro adds a registered Parity output tracking XOR of Q.
module universal_shift_reg #(
  parameter int BITS = 8,
  parameter int CW   = $clog2(BITS+1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Load,
  input  logic [BITS-1:0] data,
  input  logic [2:0]      Mode,
  input  logic            En,
  input  logic            Start,
  input  logic [CW-1:0]   Count,
  input  logic            SerInL,
  input  logic            SerInR,
  output logic [BITS-1:0] Q,
  output logic            SerOutL,
  output logic            SerOutR,
  output logic            Busy,
  output logic            Done
`ifdef USR_PARITY_EN
  ,
  output logic            Parity
`endif
);

  logic [BITS-1:0] q_q, q_d;
  logic [2:0]      mode_q, mode_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  function automatic logic [BITS-1:0] apply_op(input logic [2:0] m,
                                                input logic [BITS-1:0] v,
                                                input logic sl,
                                                input logic sr);
    logic [BITS-1:0] r;
    case (m)
      3'b001:  r = {v[BITS-2:0], sr};
      3'b010:  r = {sl, v[BITS-1:1]};
      3'b011:  r = {v[BITS-2:0], v[BITS-1]};
      3'b100:  r = {v[0], v[BITS-1:1]};
      3'b101:  r = {v[BITS-1], v[BITS-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    q_d    = q_q;
    mode_d = mode_q;
    rem_d  = rem_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (Load) begin
      // Load aborts any burst silently
      q_d    = data;
      busy_d = 1'b0;
      rem_d  = '0;
    end else if (busy_q) begin
      q_d   = apply_op(mode_q, q_q, SerInL, SerInR);
      rem_d = rem_q - 1'b1;
      if (rem_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (Start) begin
      mode_d = Mode;
      rem_d  = Count;
      if (Count != '0) busy_d = 1'b1;
      else             done_d = 1'b1;
    end else if (En) begin
      q_d = apply_op(Mode, q_q, SerInL, SerInR);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= '0;
      mode_q <= 3'b000;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef USR_PARITY_EN
  logic parity_q;
  // Tracking next Q keeps parity aligned with the Q it describes
  always_ff @(posedge CLK) begin
    if (RST) parity_q <= 1'b0;
    else     parity_q <= ^q_d;
  end
  assign Parity = parity_q;
`endif

  assign Q       = q_q;
  assign SerOutL = q_q[BITS-1];
  assign SerOutR = q_q[0];
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg (BITS=8); parity checks when USR_PARITY_EN is defined.
module tb_universal_shift_reg;
  localparam int BITS = 8;
  localparam int CW   = $clog2(BITS+1);

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            Load = 1'b0;
  logic [BITS-1:0] data = '0;
  logic [2:0]      Mode = 3'b000;
  logic            En = 1'b0;
  logic            Start = 1'b0;
  logic [CW-1:0]   Count = '0;
  logic            SerInL = 1'b0;
  logic            SerInR = 1'b0;
  logic [BITS-1:0] Q;
  logic            SerOutL, SerOutR, Busy, Done;
`ifdef USR_PARITY_EN
  logic            Parity;
`endif

  int checks = 0;
  int passes = 0;

  universal_shift_reg #(.BITS(BITS), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .Load(Load), .data(data), .Mode(Mode), .En(En),
    .Start(Start), .Count(Count), .SerInL(SerInL), .SerInR(SerInR),
    .Q(Q), .SerOutL(SerOutL), .SerOutR(SerOutR), .Busy(Busy), .Done(Done)
`ifdef USR_PARITY_EN
    , .Parity(Parity)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [BITS-1:0] v);
    Load = 1'b1; data = v;
    tick();
    Load = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++; if (Q !== 8'h00) $display("FAIL reset_q got=%h exp=00", Q); else passes++;
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL reset_bd got=%b%b exp=00", Busy, Done); else passes++;
    RST = 1'b0;
    do_load(8'h0A);
    checks++; if (Q !== 8'h0A) $display("FAIL load_q got=%h exp=0a", Q); else passes++;
    checks++; if (SerOutR !== 1'b0 || SerOutL !== 1'b0) $display("FAIL serout got=%b%b exp=00", SerOutL, SerOutR); else passes++;
  endtask

  task automatic test_free_run();
    logic [BITS-1:0] exp_seq [6];
    exp_seq = '{8'h15, 8'h2B, 8'h57, 8'hAF, 8'h5F, 8'hBF};
    En = 1'b1; Mode = 3'b001; SerInR = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (Q !== exp_seq[i]) $display("FAIL shl_%0d got=%h exp=%h", i, Q, exp_seq[i]); else passes++;
    end
    checks++; if (SerOutL !== 1'b1 || SerOutR !== 1'b1) $display("FAIL serout_bf got=%b%b exp=11", SerOutL, SerOutR); else passes++;
    Mode = 3'b010; SerInL = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (Q !== 8'h0B) $display("FAIL shr got=%h exp=0b", Q); else passes++;
    En = 1'b0; SerInR = 1'b0;
  endtask

  task automatic test_burst_rotate();
    do_load(8'h81);
    Mode = 3'b011; Start = 1'b1; Count = 3;
    tick();
    checks++; if (Q !== 8'h81 || Busy !== 1'b1) $display("FAIL rol_start got=%h/%b exp=81/1", Q, Busy); else passes++;
    Start = 1'b0; Mode = 3'b010; En = 1'b1;
    tick();
    checks++; if (Q !== 8'h03 || Busy !== 1'b1 || Done !== 1'b0) $display("FAIL rol_1 got=%h/%b/%b exp=03/1/0", Q, Busy, Done); else passes++;
    tick();
    checks++; if (Q !== 8'h06 || Busy !== 1'b1) $display("FAIL rol_2 got=%h/%b exp=06/1", Q, Busy); else passes++;
    Start = 1'b1; Mode = 3'b100;
    tick();
    checks++; if (Q !== 8'h0C || Busy !== 1'b0 || Done !== 1'b1) $display("FAIL rol_end got=%h/%b/%b exp=0c/0/1", Q, Busy, Done); else passes++;
    Start = 1'b0; En = 1'b0; Mode = 3'b000;
    tick();
    checks++; if (Q !== 8'h0C || Done !== 1'b0 || Busy !== 1'b0) $display("FAIL rol_after got=%h/%b/%b exp=0c/0/0", Q, Busy, Done); else passes++;
  endtask

  task automatic test_burst_asr_zero();
    do_load(8'h80);
    Mode = 3'b101; Start = 1'b1; Count = 2;
    tick();
    Start = 1'b0;
    tick();
    checks++; if (Q !== 8'hC0 || Busy !== 1'b1) $display("FAIL asr_1 got=%h/%b exp=c0/1", Q, Busy); else passes++;
    tick();
    checks++; if (Q !== 8'hE0 || Busy !== 1'b0 || Done !== 1'b1) $display("FAIL asr_end got=%h/%b/%b exp=e0/0/1", Q, Busy, Done); else passes++;
    tick();
    Start = 1'b1; Count = 0; Mode = 3'b001; En = 1'b1; SerInR = 1'b1;
    tick();
    checks++; if (Q !== 8'hE0 || Busy !== 1'b0 || Done !== 1'b1) $display("FAIL cnt0 got=%h/%b/%b exp=e0/0/1", Q, Busy, Done); else passes++;
    Start = 1'b0; En = 1'b0; SerInR = 1'b0; Mode = 3'b000;
    tick();
    checks++; if (Q !== 8'hE0 || Done !== 1'b0) $display("FAIL cnt0_after got=%h/%b exp=e0/0", Q, Done); else passes++;
  endtask

  task automatic test_abort();
    do_load(8'h5A);
    Mode = 3'b100; Start = 1'b1; Count = 8;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (Q !== 8'h4B || Busy !== 1'b1) $display("FAIL ror_3 got=%h/%b exp=4b/1", Q, Busy); else passes++;
    do_load(8'h33);
    checks++; if (Q !== 8'h33 || Busy !== 1'b0 || Done !== 1'b0) $display("FAIL load_abort got=%h/%b/%b exp=33/0/0", Q, Busy, Done); else passes++;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (Done !== 1'b0 || Q !== 8'h33) $display("FAIL abort_idle_%0d got=%h/%b exp=33/0", i, Q, Done); else passes++;
    end
    do_load(8'h5A);
    Start = 1'b1; Count = 8;
    tick();
    Start = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (Q !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) $display("FAIL rst_mid got=%h/%b/%b exp=00/0/0", Q, Busy, Done); else passes++;
    tick();
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL rst_after got=%b/%b exp=0/0", Busy, Done); else passes++;
  endtask

  task automatic test_rotate_full();
    do_load(8'h5A);
    Mode = 3'b011; Start = 1'b1; Count = 8;
    tick();
    Start = 1'b0; Mode = 3'b000;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (Busy !== 1'b1 || Q !== 8'h2D) $display("FAIL rol8_7 got=%h/%b exp=2d/1", Q, Busy); else passes++;
    tick();
    checks++; if (Q !== 8'h5A || Busy !== 1'b0 || Done !== 1'b1) $display("FAIL rol8 got=%h/%b/%b exp=5a/0/1", Q, Busy, Done); else passes++;
    tick();
  endtask

`ifdef USR_PARITY_EN
  task automatic test_parity();
    do_load(8'h07);
    checks++; if (Parity !== 1'b1) $display("FAIL par_07 got=%b exp=1", Parity); else passes++;
    Mode = 3'b001; En = 1'b1; SerInR = 1'b0;
    tick();
    En = 1'b0; Mode = 3'b000;
    checks++; if (Q !== 8'h0E || Parity !== 1'b1) $display("FAIL par_0e got=%h/%b exp=0e/1", Q, Parity); else passes++;
    do_load(8'h03);
    checks++; if (Parity !== 1'b0) $display("FAIL par_03 got=%b exp=0", Parity); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_burst_rotate();
    test_burst_asr_zero();
    test_abort();
    test_rotate_full();
`ifdef USR_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
